// File: rtl/order_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : order_arbiter
//  Purpose  : Round-robin arbiter sharing one matching-engine input among
//             N_SRC order sources. The winning {side, price} order is
//             registered into a one-deep output slot; zero-price orders are
//             consumed and counted as drops instead of being forwarded.
//  Ports    : clk, reset (sync, active-low)
//             req_valid/req_side/req_price  per-source order requests
//             req_ready                     per-source accept (one-hot or 0)
//             out_valid/out_ready           downstream handshake
//             out_side/out_price/out_src    held order and its source index
//             issued_cnt/drop_cnt           saturating 16-bit statistics
//  Revision : 1.0  initial release
// ============================================================================
module order_arbiter #(
    parameter int N_SRC   = 4,
    parameter int SRC_W   = 2,
    parameter int PRICE_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_SRC-1:0]           req_valid,
    input  logic [N_SRC-1:0]           req_side,
    input  logic [N_SRC*PRICE_W-1:0]   req_price,
    output logic [N_SRC-1:0]           req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_side,
    output logic [PRICE_W-1:0]         out_price,
    output logic [SRC_W-1:0]           out_src,
    output logic [15:0]                issued_cnt,
    output logic [15:0]                drop_cnt
);

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    logic                 r_out_valid;
    logic                 r_out_side;
    logic [PRICE_W-1:0]   r_out_price;
    logic [SRC_W-1:0]     r_out_src;
    logic [SRC_W-1:0]     r_rr_ptr;
    logic [15:0]          r_issued;
    logic [15:0]          r_drop;

    logic                 w_slot_free;
    logic                 w_have_win;
    logic [SRC_W-1:0]     w_win;
    logic [SRC_W-1:0]     w_rr_next;
    logic [PRICE_W-1:0]   w_price_arr [N_SRC];
    logic [PRICE_W-1:0]   w_win_price;
    logic                 w_win_side;
    logic                 w_accept;
    logic                 w_drain;
    logic [N_SRC-1:0]     w_ready;

    // Flattened price bus split into one entry per source.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
            assign w_price_arr[gi] = req_price[gi*PRICE_W +: PRICE_W];
        end
    endgenerate

    // A held order may be replaced in the same cycle it is taken downstream.
    assign w_slot_free = !r_out_valid || out_ready;

    // Rotating priority scan starting at r_rr_ptr; the first valid hit wins.
    always_comb begin : p_winner
        int               idx;
        logic [SRC_W-1:0] idx_s;
        idx        = 0;
        idx_s      = '0;
        w_have_win = 1'b0;
        w_win      = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            idx_s = SRC_W'(idx);
            if (!w_have_win && req_valid[idx_s]) begin
                w_have_win = 1'b1;
                w_win      = idx_s;
            end
        end
    end

    assign w_win_price = w_price_arr[w_win];
    assign w_win_side  = req_side[w_win];
    assign w_accept    = reset && w_have_win && w_slot_free;
    assign w_drain     = r_out_valid && out_ready;
    assign w_rr_next   = (w_win == SRC_W'(N_SRC - 1)) ? '0 : (w_win + SRC_W'(1));

    // Grant is combinational so a source sees ready in the same cycle it asks.
    always_comb begin
        w_ready = '0;
        if (w_accept) begin
            w_ready[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_side  <= 1'b0;
            r_out_price <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
            r_issued    <= '0;
            r_drop      <= '0;
        end else begin
            if (w_drain && (r_issued != C_CNT_MAX)) begin
                r_issued <= r_issued + 16'd1;
            end

            if (w_accept) begin
                r_rr_ptr <= w_rr_next;
                if (w_win_price != '0) begin
                    r_out_valid <= 1'b1;
                    r_out_side  <= w_win_side;
                    r_out_price <= w_win_price;
                    r_out_src   <= w_win;
                end else begin
                    // Zero price: consumed, never forwarded.
                    if (r_drop != C_CNT_MAX) begin
                        r_drop <= r_drop + 16'd1;
                    end
                    if (w_drain) begin
                        r_out_valid <= 1'b0;
                    end
                end
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign req_ready  = w_ready;
    assign out_valid  = r_out_valid;
    assign out_side   = r_out_side;
    assign out_price  = r_out_price;
    assign out_src    = r_out_src;
    assign issued_cnt = r_issued;
    assign drop_cnt   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_order_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_order_arbiter
//  Purpose  : Self-checking bench for order_arbiter: vector table for the
//             per-cycle behaviour plus sequences for saturation, fairness and
//             reset during a held order.
//  Revision : 1.0  initial release
// ============================================================================
module tb_order_arbiter;

    localparam int N  = 4;
    localparam int PW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_side;
    logic [N*PW-1:0] req_price;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_ready;
    logic            out_side;
    logic [PW-1:0]   out_price;
    logic [1:0]      out_src;
    logic [15:0]     issued_cnt;
    logic [15:0]     drop_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    order_arbiter #(.N_SRC(N), .SRC_W(2), .PRICE_W(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_side   (req_side),
        .req_price  (req_price),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_side   (out_side),
        .out_price  (out_price),
        .out_src    (out_src),
        .issued_cnt (issued_cnt),
        .drop_cnt   (drop_cnt)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  vld;
        logic [3:0]  side;
        logic [31:0] price;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic        e_side;
        logic [7:0]  e_price;
        logic [1:0]  e_src;
        logic [15:0] e_iss;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] pk(input logic [7:0] p0, input logic [7:0] p1,
                                       input logic [7:0] p2, input logic [7:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    function automatic vec_t mk(input logic rst_n, input logic [3:0] vld, input logic [3:0] side,
                                input logic [31:0] price, input logic ordy, input logic [3:0] e_rdy,
                                input logic e_ov, input logic e_side, input logic [7:0] e_price,
                                input logic [1:0] e_src, input logic [15:0] e_iss,
                                input logic [15:0] e_drop);
        vec_t v;
        v.rst_n = rst_n; v.vld = vld; v.side = side; v.price = price; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_side = e_side; v.e_price = e_price;
        v.e_src = e_src; v.e_iss = e_iss; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic check_ready(input string nm, input logic [3:0] exp);
        total++;
        if (req_ready !== exp) begin
            bad++;
            $display("FAIL %s req_ready got=%b want=%b", nm, req_ready, exp);
        end
    endtask

    task automatic check_state(input string nm, input logic e_ov, input logic e_side,
                               input logic [7:0] e_price, input logic [1:0] e_src,
                               input logic [15:0] e_iss, input logic [15:0] e_drop,
                               input logic chk_data);
        logic ok;
        ok = (out_valid === e_ov) && (issued_cnt === e_iss) && (drop_cnt === e_drop);
        if (chk_data) begin
            ok = ok && (out_side === e_side) && (out_price === e_price) && (out_src === e_src);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s got ov=%b side=%b price=%0d src=%0d iss=%h drop=%h want ov=%b side=%b price=%0d src=%0d iss=%h drop=%h",
                     nm, out_valid, out_side, out_price, out_src, issued_cnt, drop_cnt,
                     e_ov, e_side, e_price, e_src, e_iss, e_drop);
        end
    endtask

    task automatic drive(input logic rst_n, input logic [3:0] vld, input logic [3:0] side,
                         input logic [31:0] price, input logic ordy);
        reset     = rst_n;
        req_valid = vld;
        req_side  = side;
        req_price = price;
        out_ready = ordy;
    endtask

    initial begin
        logic [31:0] rr_p;
        logic [3:0]  exp_g;
        int          fair_err;

        rr_p = pk(8'd10, 8'd20, 8'd30, 8'd40);

        // Reset with every source requesting.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b0, 4'b1111, 4'b1111, rr_p, 1'b1, 4'b0000, 1'b0, 1'b0, 8'd0, 2'd0, 16'd0, 16'd0));
        // Round-robin, two full rotations.
        vecs.push_back(mk(1, 4'b1111, 4'b1010, rr_p, 1, 4'b0001, 1, 0, 8'd10, 2'd0, 16'd0, 16'd0));
        vecs.push_back(mk(1, 4'b1111, 4'b1010, rr_p, 1, 4'b0010, 1, 1, 8'd20, 2'd1, 16'd1, 16'd0));
        vecs.push_back(mk(1, 4'b1111, 4'b1010, rr_p, 1, 4'b0100, 1, 0, 8'd30, 2'd2, 16'd2, 16'd0));
        vecs.push_back(mk(1, 4'b1111, 4'b1010, rr_p, 1, 4'b1000, 1, 1, 8'd40, 2'd3, 16'd3, 16'd0));
        vecs.push_back(mk(1, 4'b1111, 4'b1010, rr_p, 1, 4'b0001, 1, 0, 8'd10, 2'd0, 16'd4, 16'd0));
        vecs.push_back(mk(1, 4'b1111, 4'b1010, rr_p, 1, 4'b0010, 1, 1, 8'd20, 2'd1, 16'd5, 16'd0));
        vecs.push_back(mk(1, 4'b1111, 4'b1010, rr_p, 1, 4'b0100, 1, 0, 8'd30, 2'd2, 16'd6, 16'd0));
        vecs.push_back(mk(1, 4'b1111, 4'b1010, rr_p, 1, 4'b1000, 1, 1, 8'd40, 2'd3, 16'd7, 16'd0));
        // Backpressure: source 2 buy @55, then 5 stalled cycles with source 2 still asking.
        vecs.push_back(mk(1, 4'b0100, 4'b0100, pk(0, 0, 55, 0), 1, 4'b0100, 1, 1, 8'd55, 2'd2, 16'd8, 16'd0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 4'b0100, 4'b0100, pk(0, 0, 55, 0), 0, 4'b0000, 1, 1, 8'd55, 2'd2, 16'd8, 16'd0));
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 32'd0, 1, 4'b0000, 0, 0, 8'd0, 2'd0, 16'd9, 16'd0));
        // Zero-price drop into empty slot, then price 7, then drop concurrent with drain.
        vecs.push_back(mk(1, 4'b0010, 4'b0000, 32'd0, 1, 4'b0010, 0, 0, 8'd0, 2'd0, 16'd9, 16'd1));
        vecs.push_back(mk(1, 4'b0010, 4'b0000, pk(0, 7, 0, 0), 1, 4'b0010, 1, 0, 8'd7, 2'd1, 16'd9, 16'd1));
        vecs.push_back(mk(1, 4'b0001, 4'b0000, 32'd0, 1, 4'b0001, 0, 0, 8'd0, 2'd0, 16'd10, 16'd2));
        // Back-to-back from source 3.
        vecs.push_back(mk(1, 4'b1000, 4'b1000, pk(0, 0, 0, 100), 1, 4'b1000, 1, 1, 8'd100, 2'd3, 16'd10, 16'd2));
        vecs.push_back(mk(1, 4'b1000, 4'b1000, pk(0, 0, 0, 101), 1, 4'b1000, 1, 1, 8'd101, 2'd3, 16'd11, 16'd2));
        vecs.push_back(mk(1, 4'b1000, 4'b1000, pk(0, 0, 0, 102), 1, 4'b1000, 1, 1, 8'd102, 2'd3, 16'd12, 16'd2));
        vecs.push_back(mk(1, 4'b1000, 4'b1000, pk(0, 0, 0, 103), 1, 4'b1000, 1, 1, 8'd103, 2'd3, 16'd13, 16'd2));
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 32'd0, 1, 4'b0000, 0, 0, 8'd0, 2'd0, 16'd14, 16'd2));

        drive(1'b0, 4'b0000, 4'b0000, 32'd0, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].vld, vecs[i].side, vecs[i].price, vecs[i].ordy);
            #1;
            check_ready($sformatf("row%0d_rdy", i), vecs[i].e_rdy);
            @(posedge clk);
            #1;
            check_state($sformatf("row%0d_out", i), vecs[i].e_ov, vecs[i].e_side, vecs[i].e_price,
                        vecs[i].e_src, vecs[i].e_iss, vecs[i].e_drop,
                        vecs[i].e_ov || !vecs[i].rst_n);
        end

        // Continuous traffic up to issued_cnt = 0xFFFE; grants must rotate 0,1,2,3.
        fair_err = 0;
        for (int c = 0; c < 65521; c++) begin
            @(negedge clk);
            drive(1'b1, 4'b1111, 4'b0000, pk(1, 2, 3, 4), 1'b1);
            #1;
            exp_g = 4'(1 << (c % 4));
            if (req_ready !== exp_g) fair_err++;
            @(posedge clk);
        end
        #1;
        total++;
        if (fair_err != 0) begin
            bad++;
            $display("FAIL fairness rotation_errors got=%0d want=0", fair_err);
        end
        check_state("preload", 1, 0, 8'd1, 2'd0, 16'hFFFE, 16'd2, 1);

        // Three more orders: counter saturates.
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            drive(1'b1, 4'b1111, 4'b0000, pk(1, 2, 3, 4), 1'b1);
            #1;
            check_ready($sformatf("sat%0d_rdy", c), 4'(1 << c));
            @(posedge clk);
            #1;
            check_state($sformatf("sat%0d", c), 1, 0, 8'(c + 1), 2'(c), 16'hFFFF, 16'd2, 1);
        end

        // Reset while holding an order under backpressure.
        @(negedge clk);
        drive(1'b0, 4'b1111, 4'b0000, pk(1, 2, 3, 4), 1'b0);
        #1;
        check_ready("midrst_rdy", 4'b0000);
        @(posedge clk);
        #1;
        check_state("midrst", 0, 0, 8'd0, 2'd0, 16'd0, 16'd0, 1);

        // First edge after release grants source 0.
        @(negedge clk);
        drive(1'b1, 4'b1111, 4'b0000, pk(1, 2, 3, 4), 1'b1);
        #1;
        check_ready("release_rdy", 4'b0001);
        @(posedge clk);
        #1;
        check_state("release", 1, 0, 8'd1, 2'd0, 16'd0, 16'd0, 1);

        @(negedge clk);
        drive(1'b1, 4'b0000, 4'b0000, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
